adc_bcd_conv: RTL and testbench

ADC_BCD_CONV -- requirements
Module: adc_bcd_conv

---
 rtl/adc_bcd_pkg.sv | 10 +
 rtl/bcd_digit_adj.sv | 11 +
 rtl/adc_bcd_conv.sv | 93 +++++++++
 tb/tb_adc_bcd_conv.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_bcd_pkg.sv
// rtl/adc_bcd_pkg.sv - shared FSM encoding and BCD digit width for the binary-to-BCD converter
package adc_bcd_pkg;

    localparam int BCD_W = 4;

    // The result update is folded into the last SHIFT edge, so only two states ever hold.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble add-3 correction for one BCD digit
module bcd_digit_adj
    import adc_bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] adj
);

    assign adj = (digit >= BCD_W'(5)) ? digit + BCD_W'(3) : digit;

endmodule

// File: rtl/adc_bcd_conv.sv
// rtl/adc_bcd_conv.sv - serial binary-to-BCD converter with saturation; ADC_BCD_SCALE_EN enables input pre-scaling
module adc_bcd_conv
    import adc_bcd_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int DIGITS      = 5,
    parameter int SCALE_SHIFT = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DATA_W-1:0]         din,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      ovf
);

    localparam int WORK_W = BCD_W * DIGITS;
    localparam int CNT_W  = $clog2(DATA_W);
    localparam logic [WORK_W-1:0] NINES = {DIGITS{4'h9}};

    logic [0:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] captured;
    logic [WORK_W-1:0] work;
    logic [WORK_W-1:0] adj;
    logic [WORK_W-1:0] work_nxt;
    logic              carry;
    logic              ovf_flag;
    logic              last;
    logic              ovf_final;

`ifdef ADC_BCD_SCALE_EN
    assign captured = din >> SCALE_SHIFT;
`else
    assign captured = din;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (work[g*BCD_W +: BCD_W]),
            .adj   (adj[g*BCD_W +: BCD_W])
        );
    end

    // A bit falling out of the top digit means the value no longer fits in DIGITS digits.
    assign {carry, work_nxt} = {adj, sample[DATA_W-1]};
    assign last      = (cnt == CNT_W'(DATA_W - 1));
    assign ovf_final = ovf_flag | carry;
    assign busy      = (state == ST_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sample   <= '0;
            work     <= '0;
            ovf_flag <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sample   <= captured;
                        work     <= '0;
                        ovf_flag <= 1'b0;
                        cnt      <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    work     <= work_nxt;
                    sample   <= sample << 1;
                    ovf_flag <= ovf_final;
                    cnt      <= cnt + 1'b1;
                    if (last) begin
                        bcd   <= ovf_final ? NINES : work_nxt;
                        ovf   <= ovf_final;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_bcd_conv.sv
// tb/tb_adc_bcd_conv.sv - directed self-checking bench for adc_bcd_conv; expectations follow ADC_BCD_SCALE_EN
module tb_adc_bcd_conv;

`ifdef ADC_BCD_SCALE_EN
    localparam logic [19:0] E65535  = 20'h00511;
    localparam logic [19:0] E12800  = 20'h00100;
    localparam logic [19:0] E4321   = 20'h00033;
    localparam logic [19:0] E42     = 20'h00000;
    localparam logic [19:0] E1234   = 20'h00009;
    localparam logic [15:0] EB10000 = 16'h0078;
    localparam logic        OB10000 = 1'b0;
    localparam logic [15:0] EB9999  = 16'h0078;
`else
    localparam logic [19:0] E65535  = 20'h65535;
    localparam logic [19:0] E12800  = 20'h12800;
    localparam logic [19:0] E4321   = 20'h04321;
    localparam logic [19:0] E42     = 20'h00042;
    localparam logic [19:0] E1234   = 20'h01234;
    localparam logic [15:0] EB10000 = 16'h9999;
    localparam logic        OB10000 = 1'b1;
    localparam logic [15:0] EB9999  = 16'h9999;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [15:0] din_a, din_b;
    logic        busy_a, done_a, ovf_a;
    logic        busy_b, done_b, ovf_b;
    logic [19:0] bcd_a;
    logic [15:0] bcd_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adc_bcd_conv u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_a),
        .din   (din_a),
        .busy  (busy_a),
        .done  (done_a),
        .bcd   (bcd_a),
        .ovf   (ovf_a)
    );

    adc_bcd_conv #(.DIGITS(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_b),
        .din   (din_b),
        .busy  (busy_b),
        .done  (done_b),
        .bcd   (bcd_b),
        .ovf   (ovf_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept edge, then DATA_W shift edges; noise re-asserts start with other data mid-conversion.
    task automatic conv_a(input logic [15:0] d, input logic [19:0] eb, input logic eo,
                          input bit noise, input string tag);
        int bad;
        bad = 0;
        start_a = 1'b1;
        din_a   = d;
        step();
        start_a = 1'b0;
        din_a   = ~d;
        for (int i = 0; i < 16; i++) begin
            if (busy_a !== 1'b1 || done_a !== 1'b0) bad++;
            if (noise && (i == 3 || i == 10)) begin
                start_a = 1'b1;
                din_a   = 16'd9999;
            end else begin
                start_a = 1'b0;
            end
            step();
        end
        start_a = 1'b0;
        check({tag, " busy/done during shift"}, bad, 0);
        check({tag, " done"}, {31'd0, done_a}, 1);
        check({tag, " busy"}, {31'd0, busy_a}, 0);
        check({tag, " bcd"}, {12'd0, bcd_a}, {12'd0, eb});
        check({tag, " ovf"}, {31'd0, ovf_a}, {31'd0, eo});
    endtask

    task automatic conv_b(input logic [15:0] d, input logic [15:0] eb, input logic eo, input string tag);
        int n;
        n = 0;
        start_b = 1'b1;
        din_b   = d;
        step();
        start_b = 1'b0;
        while (done_b !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check({tag, " latency"}, n, 16);
        check({tag, " bcd"}, {16'd0, bcd_b}, {16'd0, eb});
        check({tag, " ovf"}, {31'd0, ovf_b}, {31'd0, eo});
    endtask

    initial begin
        int bad;
        int nd;
        bit expd;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        din_a   = '0;
        din_b   = '0;
        step();
        step();
        check("reset busy", {31'd0, busy_a}, 0);
        check("reset done", {31'd0, done_a}, 0);
        check("reset bcd", {12'd0, bcd_a}, 0);
        check("reset ovf", {31'd0, ovf_a}, 0);

        // First start lands on the first edge after reset release.
        rst_n = 1'b1;
        conv_a(16'd65535, E65535, 1'b0, 1'b0, "max");
        step();
        check("max done one cycle", {31'd0, done_a}, 0);
        check("max bcd held", {12'd0, bcd_a}, {12'd0, E65535});

        conv_a(16'd12800, E12800, 1'b0, 1'b0, "d12800");
        step();
        conv_a(16'd0, 20'h00000, 1'b0, 1'b0, "zero");
        step();

        conv_a(16'd4321, E4321, 1'b0, 1'b1, "ignore start");
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done_a === 1'b1 || busy_a === 1'b1) nd++;
        end
        check("ignore start extra activity", nd, 0);
        check("ignore start bcd held", {12'd0, bcd_a}, {12'd0, E4321});

        // Reset mid-conversion after a non-zero result.
        start_a = 1'b1;
        din_a   = 16'd65535;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) step();
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy_a}, 0);
        check("abort done", {31'd0, done_a}, 0);
        check("abort bcd", {12'd0, bcd_a}, 0);
        check("abort ovf", {31'd0, ovf_a}, 0);
        step();
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done_a === 1'b1) nd++;
        end
        check("abort no done", nd, 0);
        conv_a(16'd42, E42, 1'b0, 1'b0, "after abort");
        step();

        conv_b(16'd10000, EB10000, OB10000, "d4 10000");
        step();
        conv_b(16'd9999, EB9999, 1'b0, "d4 9999");
        step();

        // start held high: done lands 16 edges after each accept, accept every 17 edges.
        start_a = 1'b1;
        din_a   = 16'd1234;
        step();
        bad = 0;
        nd  = 0;
        for (int t = 1; t <= 51; t++) begin
            step();
            expd = ((t % 17) == 16);
            if (done_a !== expd) bad++;
            if (done_a === 1'b1) nd++;
            if (t >= 16 && bcd_a !== E1234) bad++;
        end
        start_a = 1'b0;
        check("continuous timing/bcd", bad, 0);
        check("continuous done count", nd, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
